// File: rtl/tshift_pkg.sv
// Shared frame-layout constants for the CAN transmit shift register.
// The receiver uses the same field positions for its mapping.
package tshift_pkg;

   localparam int FRAME_LEN_EXT = 103;
   localparam int FRAME_LEN_STD = 83;
   localparam int REG_W         = 103;
   localparam int CNT_W         = 7;

   localparam int DLC_DATA_W = 68;
   localparam int EXT_ID_W   = 18;
   localparam int BASE_ID_W  = 11;

   // Field positions common to both formats
   localparam int SOF_POS    = 102;
   localparam int BASE_ID_HI = 101;
   localparam int BASE_ID_LO = 91;

   // Extended-format fields
   localparam int SRR_POS     = 90;
   localparam int IDE_EXT_POS = 89;
   localparam int EXT_ID_HI   = 88;
   localparam int EXT_ID_LO   = 71;
   localparam int RTR_EXT_POS = 70;
   localparam int DATA_HI     = 67;
   localparam int DATA_LO     = 0;

   // Standard-format fields; the bits below DATA_STD_LO stay zero
   localparam int RTR_STD_POS = 90;
   localparam int DATA_STD_HI = 87;
   localparam int DATA_STD_LO = 20;

   localparam logic [CNT_W-1:0] REMAIN_EXT = CNT_W'(FRAME_LEN_EXT);
   localparam logic [CNT_W-1:0] REMAIN_STD = CNT_W'(FRAME_LEN_STD);

   typedef enum logic {
      FMT_STD = 1'b0,
      FMT_EXT = 1'b1
   } frame_fmt_t;

   // Builds the MSB-first frame image; reserved/dominant bits are left at 0.
   function automatic logic [REG_W-1:0] frame_image(
      input frame_fmt_t             fmt,
      input logic                   rtr,
      input logic [DLC_DATA_W-1:0]  dlc_data,
      input logic [EXT_ID_W-1:0]    ext_id,
      input logic [BASE_ID_W-1:0]   base_id
   );
      logic [REG_W-1:0] img;
      img                         = '0;
      img[SOF_POS]                = 1'b0;
      img[BASE_ID_HI:BASE_ID_LO]  = base_id;
      if (fmt == FMT_EXT) begin
         img[SRR_POS]               = 1'b1;
         img[IDE_EXT_POS]           = 1'b1;
         img[EXT_ID_HI:EXT_ID_LO]   = ext_id;
         img[RTR_EXT_POS]           = rtr;
         img[DATA_HI:DATA_LO]       = dlc_data;
      end else begin
         img[RTR_STD_POS]           = rtr;
         img[DATA_STD_HI:DATA_STD_LO] = dlc_data;
      end
      return img;
   endfunction

endpackage

// File: rtl/tshift_cell.sv
// One stage of the transmit shift register: load beats shift, reset beats both.
module tshift_cell (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic shift,
   input  logic load_bit,
   input  logic shift_in,
   output logic q
);

   always_ff @(posedge clock) begin
      if (!reset)
         q <= 1'b0;
      else if (load)
         q <= load_bit;
      else if (shift)
         q <= shift_in;
   end

endmodule

// File: rtl/tshiftreg2.sv
// CAN transmit shift register: parallel frame load, one MSB-first shift per
// shift-request high period, with a count of frame bits still to send.
module tshiftreg2
   import tshift_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  activ,
   input  logic                  tcrc,
   input  logic                  load,
   input  logic                  extended,
   input  logic                  rtr,
   input  logic [DLC_DATA_W-1:0] mesin_a,
   input  logic [EXT_ID_W-1:0]   mesin_b,
   input  logic [BASE_ID_W-1:0]  mesin_c,
   output logic                  bitout,
   output logic [CNT_W-1:0]      remain,
   output logic                  empty
);

   logic             activ_int;
   logic             shift_en;
   logic             edged;
   logic [CNT_W-1:0] remain_cnt;
   logic [REG_W-1:0] load_data;
   logic [REG_W-1:0] q_bits;
   logic [REG_W-1:0] shift_src;
   frame_fmt_t       fmt;

   assign activ_int = activ & ~tcrc;
   assign fmt       = frame_fmt_t'(extended);
   assign load_data = frame_image(fmt, rtr, mesin_a, mesin_b, mesin_c);
   assign shift_src = {q_bits[REG_W-2:0], 1'b0};

   genvar gi;
   generate
      for (gi = 0; gi < REG_W; gi++) begin : g_cell
         tshift_cell u_cell (
            .clock    (clock),
            .reset    (reset),
            .load     (load),
            .shift    (shift_en),
            .load_bit (load_data[gi]),
            .shift_in (shift_src[gi]),
            .q        (q_bits[gi])
         );
      end
   endgenerate

   // One-shot: a single enable per high period of the shift request.
   always_ff @(posedge clock) begin
      if (!reset) begin
         shift_en <= 1'b0;
         edged    <= 1'b0;
      end else if (activ_int) begin
         if (!edged) begin
            shift_en <= 1'b1;
            edged    <= 1'b1;
         end else begin
            shift_en <= 1'b0;
         end
      end else begin
         shift_en <= 1'b0;
         edged    <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset)
         remain_cnt <= '0;
      else if (load)
         remain_cnt <= (fmt == FMT_EXT) ? REMAIN_EXT : REMAIN_STD;
      else if (shift_en && (remain_cnt != '0))
         remain_cnt <= remain_cnt - 1'b1;
   end

   assign bitout = q_bits[SOF_POS];
   assign remain = remain_cnt;
   assign empty  = (remain_cnt == '0);

endmodule

// File: doc/tshiftreg2.md
TSHIFTREG2 -- requirements
Module: tshiftreg2

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  reset, synchronous, active-low
- activ  in  1  MACFSM actvtsft, shift request level
- tcrc  in  1  MACFSM CRC phase; masks activ
- load  in  1  parallel-load strobe, one cycle
- extended  in  1  frame format at load: 1 = extended, 0 = standard
- rtr  in  1  remote frame flag at load
- mesin_a  in  68  DLC+data, DLC at [67:64]
- mesin_b  in  18  extended identifier
- mesin_c  in  11  base identifier
- bitout  out  1  serial transmit bit, MSB first
- remain  out  7  frame bits not yet shifted
- empty  out  1  high when remain = 0

REQ-002 Parameters: none; all widths are fixed by package constants.

Function
REQ-003 The block SHALL hold a 103-bit register q, with bitout = q[102] combinationally.
REQ-004 On load=1 with extended=1, q SHALL receive {0 (SOF), mesin_c, 1 (SRR), 1 (IDE), mesin_b, rtr, 0 (r1), 0 (r0), mesin_a}, and remain SHALL be set to 103.
REQ-005 On load=1 with extended=0, q[102:20] SHALL receive {0, mesin_c, rtr, 0 (IDE), 0 (r0), mesin_a}, q[19:0] SHALL be 0, and remain SHALL be set to 83.
REQ-006 The internal shift request SHALL be activ_i = activ & ~tcrc.
REQ-007 Edge logic: on an edge with activ_i=1 and edged=0, the block SHALL set enable_i<=1 and edged<=1.
REQ-008 On an edge with activ_i=1 and edged=1, the block SHALL set enable_i<=0.
REQ-009 On an edge with activ_i=0, the block SHALL set edged<=0 and enable_i<=0.
REQ-010 At most one shift SHALL occur per activ_i high period.
REQ-011 On an edge with enable_i=1 and load=0, q SHALL become {q[101:0],0}, and remain SHALL decrement when nonzero.
REQ-012 Latency: activ_i is sampled high at edge k, enable_i is high after edge k, and bitout shows the next bit after edge k+1.
REQ-013 load SHALL take priority over a simultaneous enable_i; the shift is dropped and the edged state is unaffected.
REQ-014 At remain=0, shifts SHALL continue inserting 0, remain SHALL stay at 0, and empty SHALL stay at 1.
REQ-015 tcrc rising mid-frame SHALL freeze q and remain.
REQ-016 A reset asserted mid-frame SHALL abort the frame; the frame resumes only after a new load.
REQ-017 empty SHALL be registered-consistent with remain, meaning it is derived from the remain register with no extra delay.

Reset
REQ-018 When reset=0 at a rising edge, the block SHALL clear q to all zeros, remain to 0, enable_i to 0 and edged to 0.
REQ-019 After reset: bitout=0, remain=0, empty=1.
REQ-020 Reset SHALL override load and enable_i on the same edge.

Structure
REQ-021 A shared package tshift_pkg SHALL hold:
- FRAME_LEN_EXT=103
- FRAME_LEN_STD=83
- REG_W=103
- CNT_W=7
- field bit-position constants (SOF 102, BASE_ID 101:91, EXT_ID 88:71, DATA 67:0)
These constants are shared with the receiver's field mapping.
REQ-022 The register SHALL be built from 103 instances of sub-module tshift_cell.
REQ-023 Each tshift_cell SHALL be one flip-flop with sync reset, load with load-data, and shift with the previous stage's q (stage 0 takes 0).
REQ-024 The edge logic and the remain counter SHALL reside in the top module.

Verification
REQ-025 Extended load: mesin_c=11'h5A5, mesin_b=18'h2AAAA, rtr=0, mesin_a={4'h8,64'h0123456789ABCDEF} → 103 activ pulses serialize exactly the REQ-004 bit sequence, after which remain=0 and empty=1.
REQ-026 Standard load: mesin_c=11'h7FF, rtr=1, mesin_a=68'h0 → first bits out are 0 then eleven 1s, then 1, 0, 0; remain goes 83→0 in 83 pulses; after that bitout=0.
REQ-027 Held activ: activ held high for 10 cycles → exactly one shift, and remain decrements by 1.
REQ-028 activ toggling every cycle → one shift per two cycles.
REQ-029 tcrc=1 while activ pulses 5 times → q and remain unchanged.
REQ-030 load and enable_i in the same cycle → register equals the freshly loaded value and remain=103.
REQ-031 reset=0 mid-frame at remain=40 → next cycle remain=0, empty=1, bitout=0.
REQ-032 Following a mid-frame reset, an activ pulse without a load → no change to q or remain.
